// File: rtl/timer_counter.sv
// Programmable down-counting timer behind the processor bridge.
// Three word registers (CTRL, PRESET, COUNT) with combinational read-back,
// one-shot or auto-reload operation and a maskable interrupt request.
module timer_counter #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       Addr,
  input  logic             We,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataOut,
  output logic             IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } stateType;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  stateType         stateReg, stateNext;
  logic [3:0]       ctrlReg, ctrlNext;
  logic [WIDTH-1:0] presetReg, presetNext;
  logic [WIDTH-1:0] countReg, countNext;
  logic             irqFlagReg, irqFlagNext;

  logic enable;
  logic autoReload;
  logic irqMask;
  logic ctrlWrite;
  logic presetWrite;

  // CTRL field decode; only Mode 01 reloads, the other modes behave as one-shot
  assign enable      = ctrlReg[0];
  assign autoReload  = (ctrlReg[2:1] == 2'b01);
  assign irqMask     = ctrlReg[3];
  assign ctrlWrite   = We && (Addr == ADDR_CTRL);
  assign presetWrite = We && (Addr == ADDR_PRESET);

  // State and register update
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateReg   <= IDLE;
      ctrlReg    <= '0;
      presetReg  <= '0;
      countReg   <= '0;
      irqFlagReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      ctrlReg    <= ctrlNext;
      presetReg  <= presetNext;
      countReg   <= countNext;
      irqFlagReg <= irqFlagNext;
    end
  end

  // Next-state logic; CPU writes to CTRL override the FSM's Enable clear,
  // and entering INT sets the flag even when a CTRL write would clear it
  always_comb begin
    stateNext   = stateReg;
    ctrlNext    = ctrlReg;
    presetNext  = presetReg;
    countNext   = countReg;
    irqFlagNext = irqFlagReg;

    // Auto-reload produces a single-cycle pulse; one-shot holds until a CTRL write
    if (autoReload || ctrlWrite) begin
      irqFlagNext = 1'b0;
    end

    case (stateReg)
      IDLE: begin
        if (enable) begin
          stateNext = LOAD;
        end
      end
      LOAD: begin
        countNext = presetReg;
        stateNext = CNT;
      end
      CNT: begin
        if (!enable) begin
          stateNext = IDLE;
        end else if (countReg == '0) begin
          stateNext = INT;
        end else begin
          countNext = countReg - WIDTH'(1);
        end
      end
      INT: begin
        irqFlagNext = 1'b1;
        if (autoReload) begin
          stateNext = LOAD;
        end else begin
          ctrlNext[0] = 1'b0;
          stateNext   = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (ctrlWrite) begin
      ctrlNext = DataIn[3:0];
    end
    if (presetWrite) begin
      presetNext = DataIn;
    end
  end

  // Zero-latency read mux
  always_comb begin
    DataOut = '0;
    case (Addr)
      ADDR_CTRL:   DataOut = {{(WIDTH-4){1'b0}}, ctrlReg};
      ADDR_PRESET: DataOut = presetReg;
      ADDR_COUNT:  DataOut = countReg;
      default:     DataOut = '0;
    endcase
  end

  assign IRQ = irqFlagReg & irqMask;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: each task drives one scenario and
// compares the observed outputs against hand-computed values.
module tb_timer_counter;

  logic        Clk;
  logic        Reset;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        IRQ;

  int checks;
  int errors;

  timer_counter #(.WIDTH(32)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Addr    (Addr),
    .We      (We),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .IRQ     (IRQ)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one edge and settle 1 time unit after it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Bus write captured on the next edge
  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    Addr   = a;
    DataIn = d;
    We     = 1'b1;
    @(posedge Clk);
    #1;
    We = 1'b0;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = DataOut;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", IRQ);
    end
    for (int a = 0; a < 4; a++) begin
      readReg(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d: got 0x%08h expected 0x00000000", a, d);
      end
    end
    writeReg(2'd2, 32'h1234);
    readReg(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL count_readonly: got 0x%08h expected 0x00000000", d);
    end
    $display("test_reset done");
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    writeReg(2'd1, 32'd5);
    writeReg(2'd0, 32'h9);          // edge 0
    tick();
    tick();                          // edge 2: COUNT=5
    readReg(2'd2, d);
    checks++;
    if (d !== 32'd5) begin
      errors++;
      $display("FAIL oneshot_load: got %0d expected 5", d);
    end
    for (int e = 4; e >= 0; e--) begin
      tick();
      readReg(2'd2, d);
      checks++;
      if (d !== 32'(e)) begin
        errors++;
        $display("FAIL oneshot_count: got %0d expected %0d", d, e);
      end
    end
    tick();                          // edge 8
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_irq_early: got %b expected 0", IRQ);
    end
    tick();                          // edge 9
    checks++;
    if (IRQ !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_irq_rise: got %b expected 1", IRQ);
    end
    readReg(2'd0, d);
    checks++;
    if (d !== 32'h8) begin
      errors++;
      $display("FAIL oneshot_ctrl: got 0x%0h expected 0x8", d);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (IRQ !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_irq_sticky: got %b expected 1", IRQ);
    end
    writeReg(2'd0, 32'h0);
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_irq_clear: got %b expected 0", IRQ);
    end
    $display("test_oneshot done");
  endtask

  task automatic test_preset_zero();
    writeReg(2'd1, 32'd0);
    writeReg(2'd0, 32'h9);          // edge 0
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL preset0_irq_edge3: got %b expected 0", IRQ);
    end
    tick();                          // edge 4
    checks++;
    if (IRQ !== 1'b1) begin
      errors++;
      $display("FAIL preset0_irq_edge4: got %b expected 1", IRQ);
    end
    writeReg(2'd0, 32'h0);
    $display("test_preset_zero done");
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    logic [31:0] expCount;
    logic        expIrq;
    int          k;
    writeReg(2'd1, 32'd3);
    writeReg(2'd0, 32'hB);          // edge 0
    for (int e = 1; e <= 20; e++) begin
      tick();
      k = (e - 2) % 6;
      if (e < 2) begin
        expCount = 32'd0;
        expIrq   = 1'b0;
      end else begin
        expCount = (k <= 3) ? 32'(3 - k) : 32'd0;
        expIrq   = (k == 5);
      end
      readReg(2'd2, d);
      checks++;
      if (d !== expCount) begin
        errors++;
        $display("FAIL auto_count edge=%0d: got %0d expected %0d", e, d, expCount);
      end
      checks++;
      if (IRQ !== expIrq) begin
        errors++;
        $display("FAIL auto_irq edge=%0d: got %b expected %b", e, IRQ, expIrq);
      end
    end
    writeReg(2'd0, 32'h0);
    tick();
    tick();
    $display("test_autoreload done");
  endtask

  task automatic test_masking();
    logic [31:0] d;
    writeReg(2'd1, 32'd2);
    writeReg(2'd0, 32'h1);          // edge 0, flag sets after edge 6
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (IRQ !== 1'b0) begin
        errors++;
        $display("FAIL mask_irq edge=%0d: got %b expected 0", e, IRQ);
      end
    end
    readReg(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mask_ctrl_enable_cleared: got 0x%0h expected 0x0", d);
    end
    writeReg(2'd0, 32'h8);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (IRQ !== 1'b0) begin
        errors++;
        $display("FAIL mask_after_im: got %b expected 0", IRQ);
      end
      tick();
    end
    writeReg(2'd0, 32'h0);
    $display("test_masking done");
  endtask

  task automatic test_pause_reload();
    logic [31:0] d;
    writeReg(2'd1, 32'd10);
    writeReg(2'd0, 32'h1);          // edge 0
    for (int i = 0; i < 5; i++) tick();   // edge 5: COUNT=7
    writeReg(2'd0, 32'h0);          // edge 6: COUNT=6, Enable=0
    readReg(2'd2, d);
    checks++;
    if (d !== 32'd6) begin
      errors++;
      $display("FAIL pause_at6: got %0d expected 6", d);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      readReg(2'd2, d);
      checks++;
      if (d !== 32'd6) begin
        errors++;
        $display("FAIL pause_hold: got %0d expected 6", d);
      end
    end
    writeReg(2'd0, 32'h1);          // edge r
    tick();
    readReg(2'd2, d);
    checks++;
    if (d !== 32'd6) begin
      errors++;
      $display("FAIL pause_idle_to_load: got %0d expected 6", d);
    end
    tick();                          // edge r+2
    readReg(2'd2, d);
    checks++;
    if (d !== 32'd10) begin
      errors++;
      $display("FAIL pause_reload: got %0d expected 10", d);
    end
    writeReg(2'd0, 32'h0);
    tick();
    $display("test_pause_reload done");
  endtask

  task automatic test_collision();
    logic [31:0] d;
    writeReg(2'd1, 32'd1);
    writeReg(2'd0, 32'h9);          // edge 0, INT state after edge 4
    for (int i = 0; i < 4; i++) tick();
    writeReg(2'd0, 32'h9);          // lands on the INT edge (5)
    checks++;
    if (IRQ !== 1'b1) begin
      errors++;
      $display("FAIL collide_irq: got %b expected 1", IRQ);
    end
    readReg(2'd0, d);
    checks++;
    if (d !== 32'h9) begin
      errors++;
      $display("FAIL collide_ctrl: got 0x%0h expected 0x9", d);
    end
    tick();
    tick();                          // edge 7: reloaded
    readReg(2'd2, d);
    checks++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL collide_restart: got %0d expected 1", d);
    end
    for (int i = 0; i < 3; i++) tick();   // edge 10: second INT done
    readReg(2'd0, d);
    checks++;
    if (d !== 32'h8) begin
      errors++;
      $display("FAIL collide_second_int: got 0x%0h expected 0x8", d);
    end
    writeReg(2'd0, 32'h0);
    $display("test_collision done");
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d;
    writeReg(2'd1, 32'd5);
    writeReg(2'd0, 32'h9);          // edge 0
    for (int i = 0; i < 4; i++) tick();   // edge 4: COUNT=3
    readReg(2'd2, d);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL midrun_count: got %0d expected 3", d);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL midrun_irq: got %b expected 0", IRQ);
    end
    for (int a = 0; a < 3; a++) begin
      readReg(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL midrun_reg addr=%0d: got 0x%08h expected 0", a, d);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (IRQ !== 1'b0) begin
        errors++;
        $display("FAIL midrun_no_irq: got %b expected 0", IRQ);
      end
    end
    readReg(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL midrun_count_idle: got %0d expected 0", d);
    end
    $display("test_reset_midrun done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    We     = 1'b0;
    Addr   = 2'd0;
    DataIn = 32'h0;
    test_reset();
    test_oneshot();
    test_preset_zero();
    test_autoreload();
    test_masking();
    test_pause_reload();
    test_collision();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Programmable down-counting timer, memory-mapped behind the CPU's processor bridge (PrAddr/PrWD/PrWe/PrRD side).
- Consumes bridge writes, returns read data, and raises an interrupt request wired to cpu HWInt[2].
- Supports one-shot and auto-reload modes with a maskable, sticky or pulsed IRQ.
- Mapped at 0x0000_7F00–0x0000_7F0B; the bridge decodes the window and supplies word address bits [3:2].

Parameters:
- WIDTH, 32, width of PRESET, COUNT and data ports.

Ports:
- Clk     in   1      system clock, rising edge
- Reset   in   1      synchronous, active-high reset
- Addr    in   2      word select (PrAddr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- We      in   1      write strobe, already qualified by the bridge's address decode
- DataIn  in   WIDTH  write data (PrWD)
- DataOut out  WIDTH  read data, combinational from Addr
- IRQ     out  1      interrupt request to HWInt[2]

Behaviour:
- Registers:
  - CTRL[3:0]: bit0 Enable, bits[2:1] Mode, bit3 IM (interrupt mask enable). Mode 00 = one-shot; Mode 01 = auto-reload; Modes 10/11 behave as 00.
  - PRESET: R/W.
  - COUNT: read-only.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Outputs after reset: IRQ=0, DataOut=0 for Addr=0/2 and Addr=3; DataOut=PRESET (0) for Addr=1.
- Reset asserted mid-count returns everything to the reset state at the next edge; no IRQ is produced.
- Writes (We=1, registered at the edge):
  - Addr0: CTRL <= DataIn[3:0].
  - Addr1: PRESET <= DataIn.
  - Addr2 and Addr3: ignored.
- Reads (combinational, zero latency):
  - Addr0: {28'b0, CTRL}.
  - Addr1: PRESET.
  - Addr2: COUNT.
  - Addr3: 0.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable, go to LOAD. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !Enable, go to IDLE and COUNT holds. Else if COUNT==0, go to INT. Else COUNT <= COUNT-1.
  - INT, Mode 0: irq_flag <= 1; CTRL.Enable <= 0; go to IDLE.
  - INT, Mode 1: irq_flag <= 1 for exactly one cycle; go to LOAD.
- IRQ = irq_flag & CTRL.IM.
- irq_flag clearing:
  - Mode 0: sticky until any write to CTRL.
  - Mode 1: cleared at the next edge unless INT is re-entered.
- Latency: write of Enable=1 at edge n with PRESET=P gives COUNT=P after edge n+2, COUNT=0 after edge n+2+P, and irq_flag=1 after edge n+4+P.
- Auto-reload period: P+3 cycles; the IRQ pulse is one cycle wide.
- Boundary and simultaneous events:
  - PRESET=0: COUNT stays 0 and INT follows at edge n+3; irq_flag=1 after edge n+4.
  - PRESET=0xFFFF_FFFF: no overflow logic is needed; only decrement is performed.
  - PRESET written during CNT does not disturb COUNT; the new value is used at the next LOAD.
  - CTRL write in the same cycle as INT: CPU write data wins for CTRL (including Enable), and irq_flag is still set (set beats clear).
  - Enable cleared during CNT: COUNT freezes. Re-enabling goes IDLE→LOAD, reloading from PRESET; there is no resume.
  - IM=0 masks IRQ only; irq_flag still updates, so setting IM later exposes a pending Mode-0 flag.
  - Mode changed mid-count takes effect at the next INT.

Test Plan:
- Reset check: assert Reset 2 cycles → IRQ=0; reads of Addr0/1/2 all return 0; a write to Addr2 (0x1234) leaves COUNT=0.
- One-shot: write PRESET=5, then CTRL=0x9 at edge 0 → COUNT reads 5,4,3,2,1,0; IRQ rises after edge 9 and stays high; CTRL reads 0x8. Writing CTRL=0 drops IRQ at the next edge.
- Auto-reload: PRESET=3, CTRL=0xB → single-cycle IRQ pulses every 6 cycles; COUNT reloads to 3 after each pulse.
- Masking: one-shot with PRESET=2, CTRL=0x1 → IRQ never rises while irq_flag sets. Then write CTRL=0x8 → flag clears (CTRL write), IRQ stays 0.
- Pause/reload: PRESET=10, enable; disable at COUNT=6 → COUNT holds 6 for 5 cycles. Re-enable → COUNT reloads to 10, not 6.
- Collision and reset mid-run: write CTRL=0x9 on the exact INT cycle → IRQ=1 and Enable=1, so the count restarts. Separately, assert Reset at COUNT=3 → all registers 0 and IRQ=0 next cycle.
